// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update/maintenance controller.
package btb_pkg;

    localparam int unsigned BTB_IDX_W   = 5;
    localparam int unsigned BTB_TAG_W   = 25;
    localparam int unsigned BTB_TGT_W   = 32;
    localparam int unsigned BTB_ENTRY_W = 58;
    localparam int unsigned BTB_REC_W   = BTB_IDX_W + BTB_ENTRY_W;
    localparam int unsigned BTB_ENTRIES = 32;

    typedef struct packed {
        logic [BTB_IDX_W-1:0]   idx;
        logic [BTB_ENTRY_W-1:0] entry;
    } btb_rec_t;

    typedef enum logic {
        IDLE,
        SWEEP
    } btb_state_e;

    // Taken branches install {1, tag, target}; not-taken hits invalidate the entry.
    function automatic btb_rec_t btb_make_rec(input logic [31:0] pc, input logic [31:0] tgt,
                                              input logic taken);
        btb_rec_t rec;
        rec.idx   = pc[6:2];
        rec.entry = taken ? {1'b1, pc[31:7], tgt} : {1'b0, pc[31:7], 32'h0};
        return rec;
    endfunction

endpackage

// File: rtl/m_btb_fifo.sv
// Synchronous FIFO for pending BTB update records, with a one-cycle clear.
module m_btb_fifo
    import btb_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = BTB_REC_W,
    parameter int unsigned CntW  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    // A push in the clear cycle lands in the freshly emptied FIFO.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (do_push) begin
            mem_d[wptr_d] = wdata_i;
            wptr_d        = wptr_d + PtrW'(1);
        end
        cnt_d = cnt_d + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/m_btb_ctrl.sv
// BTB update filter, update queue and invalidate sweep driving the BTB write port.
// Optional BTB_BYPASS_EN: an idle, empty controller loads accepted records straight to the port.
module m_btb_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CW     = 3
) (
    input  logic                   w_clock,
    input  logic                   w_reset,
    input  logic                   w_rv,
    input  logic [31:0]            w_rpc,
    input  logic [31:0]            w_rtgt,
    input  logic                   w_rtaken,
    input  logic                   w_rhit,
    output logic                   w_rready,
    input  logic                   w_flush,
    output logic                   w_busy,
    output logic                   w_we,
    output logic [BTB_IDX_W-1:0]   w_wa,
    output logic [BTB_ENTRY_W-1:0] w_wd,
    output logic [CW-1:0]          w_qcnt,
    output logic                   w_drop
);

    btb_state_e             state_q, state_d;
    logic [BTB_IDX_W-1:0]   idx_q, idx_d;
    logic                   we_q, we_d;
    logic [BTB_IDX_W-1:0]   wa_q, wa_d;
    logic [BTB_ENTRY_W-1:0] wd_q, wd_d;
    logic                   drop_q, drop_d;

    logic     need;
    logic     accept;
    logic     push;
    logic     pop;
    logic     clr;
    logic     fifo_full;
    logic     fifo_empty;
    btb_rec_t in_rec;
    btb_rec_t head_rec;
    logic     unused_pc;

    assign unused_pc = ^w_rpc[1:0];

    assign need     = w_rv & (w_rtaken | w_rhit);
    assign w_rready = ~fifo_full;
    assign accept   = need & w_rready;
    assign in_rec   = btb_make_rec(w_rpc, w_rtgt, w_rtaken);
    assign drop_d   = need & ~w_rready;

    m_btb_fifo #(
        .Depth (QDEPTH),
        .Width (BTB_REC_W),
        .CntW  (CW)
    ) u_fifo (
        .clk_i   (w_clock),
        .rst_i   (w_reset),
        .push_i  (push),
        .pop_i   (pop),
        .clr_i   (clr),
        .wdata_i (in_rec),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (w_qcnt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        clr     = 1'b0;
        push    = accept;
        case (state_q)
            IDLE: begin
                // Flush wins over a pending pop so no stale record slips out ahead of the sweep.
                if (w_flush) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    clr     = 1'b1;
                end else if (!fifo_empty) begin
                    pop  = 1'b1;
                    we_d = 1'b1;
                    wa_d = head_rec.idx;
                    wd_d = head_rec.entry;
                end
`ifdef BTB_BYPASS_EN
                else if (accept) begin
                    push = 1'b0;
                    we_d = 1'b1;
                    wa_d = in_rec.idx;
                    wd_d = in_rec.entry;
                end
`endif
            end
            SWEEP: begin
                we_d  = 1'b1;
                wa_d  = idx_q;
                wd_d  = '0;
                idx_d = idx_q + BTB_IDX_W'(1);
                if (idx_q == BTB_IDX_W'(BTB_ENTRIES - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            drop_q  <= drop_d;
        end
    end

    assign w_busy = (state_q == SWEEP);
    assign w_we   = we_q;
    assign w_wa   = wa_q;
    assign w_wd   = wd_q;
    assign w_drop = drop_q;

endmodule

// File: doc/m_btb_ctrl.md
Name: m_btb_ctrl

Overview:
Update and maintenance controller for the 32-entry direct-mapped branch target buffer (entry = valid, 25-bit tag, 32-bit target).
- Accepts branch-resolution reports from execute and filters out those that need no BTB change.
- Buffers the rest in a small FIFO and drives the BTB's single write port (we/wa/wd).
- Owns the invalidate sweep: automatic after reset and on a flush request; the sweep takes priority over queued updates.

Parameters:
QDEPTH, 4, update FIFO depth (power of two, 2..16)
CW, 3, occupancy count width, equal to log2(QDEPTH)+1

Ports:
w_clock  in  1  clock
w_reset  in  1  synchronous, active-high reset
w_rv  in  1  resolution report valid
w_rpc  in  32  PC of the resolved branch
w_rtgt  in  32  resolved target address
w_rtaken  in  1  branch was taken
w_rhit  in  1  BTB hit at fetch for this branch
w_rready  out  1  FIFO not full (count < QDEPTH)
w_flush  in  1  request to invalidate the whole BTB
w_busy  out  1  sweep in progress
w_we  out  1  BTB write enable (registered)
w_wa  out  5  BTB write index (registered)
w_wd  out  58  BTB write data {v, tag, target} (registered)
w_qcnt  out  CW  FIFO occupancy
w_drop  out  1  one-cycle pulse, asserted the cycle after a needed update was lost because the FIFO was full

Behaviour:
- Clock and reset: one clock, w_clock. Reset (w_reset) is synchronous and active-high.
- Register reset values: w_we=0, w_wa=0, w_wd=0, w_drop=0, FIFO empty, w_qcnt=0. State becomes SWEEP with idx=0, so w_busy=1 in the first cycle after reset.
- Update need:
  - need = w_rv & (w_rtaken | w_rhit).
  - Taken branch: write record {1, w_rpc[31:7], w_rtgt}.
  - Not-taken branch that hit: write record {0, w_rpc[31:7], 32'h0} (invalidate).
  - Index is always w_rpc[6:2].
  - A report with need=0 is ignored: no enqueue, no drop.
- Enqueue: when need & w_rready, the record (index + 58-bit data) is pushed.
- Drop: when need & !w_rready, the record is discarded and w_drop=1 on the next cycle.
- w_rready: does not consider a same-cycle pop.
- States:
  - IDLE: if the FIFO is non-empty, pop the head and register it onto w_we=1/w_wa/w_wd the next cycle; otherwise w_we=0 next cycle. w_flush=1 moves to SWEEP with idx=0.
  - SWEEP: each cycle registers w_we=1, w_wa=idx, w_wd=0, then increments idx. After writing idx=31, return to IDLE. Exactly 32 write cycles; no pops during SWEEP.
- Latency:
  - Report accepted in cycle N with the FIFO empty and state IDLE: FIFO holds it at N+1, w_we is high at N+2.
  - One pop per cycle, in FIFO order.
- Flush semantics:
  - Entering SWEEP clears the FIFO; discarded records are older than the flush and do not raise w_drop.
  - A report in the same cycle as w_flush is younger and is enqueued after the clear.
  - Reports during SWEEP are enqueued normally and drain after SWEEP.
  - w_flush while already in SWEEP is ignored; the sweep is not restarted.
- Same index queued twice: both writes occur in order, and the last one wins.
- Reset mid-sweep or mid-drain: FIFO is emptied and the sweep restarts at idx=0.

Optional Feature:
BTB_BYPASS_EN
- Defined: when the state is IDLE, the FIFO is empty and a report is accepted, the record loads the output registers directly (w_we at N+1) and is not pushed.
  - w_qcnt does not count bypassed records.
  - Bypass is never taken during SWEEP or with a non-empty FIFO, so ordering is preserved.
- Undefined: every record goes through the FIFO, with two-cycle minimum latency.

Decomposition:
- Package btb_pkg holds:
  - constants BTB_IDX_W=5, BTB_TAG_W=25, BTB_TGT_W=32, BTB_ENTRY_W=58;
  - a record typedef {idx, entry};
  - a state enum {IDLE, SWEEP}.
- One sub-module, m_btb_fifo: synchronous FIFO with push/pop, full/empty and count, width BTB_IDX_W+BTB_ENTRY_W, depth QDEPTH.
- The FSM, filter and output registers stay in m_btb_ctrl.

Test Plan:
- Reset sweep: release reset -> w_busy=1; w_we=1 for 32 consecutive cycles with w_wa=0..31 and w_wd=0; then w_busy=0, w_we=0.
- Taken update: w_rv=1, w_rpc=32'h0000_1234, w_rtgt=32'h0000_2000, w_rtaken=1 -> two cycles later (one with BTB_BYPASS_EN) w_we=1, w_wa=13, w_wd={1, 25'h24, 32'h2000}.
- Filter: not-taken with w_rhit=0 -> no write, w_qcnt stays 0. Not-taken with w_rhit=1, pc=32'h80 -> write w_wa=0, w_wd={0, 25'h1, 0}.
- Overflow: during a sweep, send 5 taken reports back to back with QDEPTH=4 -> w_qcnt reaches 4, w_rready=0, the 5th raises w_drop for one cycle; after the sweep, 4 writes come out in order.
- Flush with pending: 3 queued records plus w_flush together with a new report R -> 32 sweep writes, then exactly one write (R); w_drop never asserted.
- Reset mid-sweep at idx=17 -> next sweep write has w_wa=0, and the FIFO is empty.
